// File: rtl/game_flow_ctrl.sv
// Brick-breaker game-flow controller: serve/play/miss/over/win sequencing,
// BCD score, life counter and a one-cell-per-clock remaining-brick scanner.
module game_flow_ctrl #(
  parameter int unsigned LIVES       = 3,
  parameter logic [9:0]  BALL_LOST_Y = 10'd470
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          start,
  input  logic          brick_hit,
  input  logic [9:0]    ball_y,
  input  logic [1439:0] bricks,
  output logic [2:0]    state,
  output logic [1:0]    lives,
  output logic [15:0]   score,
  output logic [8:0]    bricks_left,
  output logic          run,
  output logic          serve,
  output logic          load_level
);

  localparam logic [8:0] LAST_CELL  = 9'd479;
  localparam logic [1:0] LIVES_INIT = LIVES[1:0];

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_MISS  = 3'd3,
    S_OVER  = 3'd4,
    S_WIN   = 3'd5
  } state_t;

  state_t      cur;
  state_t      nxt;
  logic [8:0]  idx;
  logic [8:0]  acc;
  logic        scan_done;
  logic [10:0] base;
  logic        occ;
  logic        enter_play;
  logic [1:0]  lives_nxt;
  logic [15:0] score_nxt;
  logic        serve_nxt;
  logic        load_nxt;

  assign state = cur;
  assign base  = 11'(idx) * 11'd3;
  assign occ   = |bricks[base +: 3];

  // Four-digit BCD increment with ripple carry; 9999 holds.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    if (v == 16'h9999) return v;
    for (int unsigned i = 0; i < 4; i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = '0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    nxt       = cur;
    lives_nxt = lives;
    score_nxt = score;
    serve_nxt = 1'b0;
    load_nxt  = 1'b0;
    case (cur)
      S_IDLE, S_OVER, S_WIN: begin
        if (start) begin
          nxt       = S_SERVE;
          load_nxt  = 1'b1;
          lives_nxt = LIVES_INIT;
          score_nxt = '0;
        end
      end
      S_SERVE: begin
        if (start) begin
          nxt       = S_PLAY;
          serve_nxt = 1'b1;
        end
      end
      S_PLAY: begin
        // Win outranks both scoring and a miss in the same cycle.
        if (scan_done && (bricks_left == '0)) begin
          nxt = S_WIN;
        end else if (tick) begin
          if (brick_hit) score_nxt = bcd_inc(score);
          if (ball_y >= BALL_LOST_Y) nxt = S_MISS;
        end
      end
      S_MISS: begin
        if (lives > 2'd1) begin
          lives_nxt = lives - 2'd1;
          nxt       = S_SERVE;
        end else begin
          lives_nxt = '0;
          nxt       = S_OVER;
        end
      end
      default: nxt = S_IDLE;
    endcase
  end

  assign enter_play = (nxt == S_PLAY) && (cur != S_PLAY);

  always_ff @(posedge clk) begin
    if (!rst) begin
      cur         <= S_IDLE;
      lives       <= LIVES_INIT;
      score       <= '0;
      bricks_left <= '0;
      run         <= 1'b0;
      serve       <= 1'b0;
      load_level  <= 1'b0;
      idx         <= '0;
      acc         <= '0;
      scan_done   <= 1'b0;
    end else begin
      cur        <= nxt;
      lives      <= lives_nxt;
      score      <= score_nxt;
      run        <= (nxt == S_PLAY);
      serve      <= serve_nxt;
      load_level <= load_nxt;
      // A fresh scan starts on PLAY entry so the win check never sees a stale map.
      if (enter_play) begin
        idx       <= '0;
        acc       <= '0;
        scan_done <= 1'b0;
      end else if (idx == LAST_CELL) begin
        bricks_left <= acc + 9'(occ);
        acc         <= '0;
        idx         <= '0;
        if (cur == S_PLAY) scan_done <= 1'b1;
      end else begin
        idx <= idx + 9'd1;
        acc <= acc + 9'(occ);
      end
    end
  end

endmodule
